// File: rtl/seven_seg_scan_bcd_pkg.sv
// Shared constants, FSM state type and helpers for the scanned BCD display feeder.
package seven_seg_pkg;

    localparam logic [3:0] BLANK_CODE = 4'hF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    // Largest value representable with n decimal digits.
    function automatic longint max_val(input int n);
        longint r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r - 1;
    endfunction

endpackage

// File: rtl/seven_seg_scan_bcd_if.sv
// Load/status and scanned-display bundle between a host and seven_seg_scan_bcd.
interface seven_seg_scan_bcd_if #(
    parameter int NUM_DIGITS = 4,
    parameter int BIN_WIDTH  = 14
);
    logic [BIN_WIDTH-1:0]  value_in;
    logic                  load;
    logic                  busy;
    logic                  overflow;
    logic [3:0]            digit_out;
    logic [NUM_DIGITS-1:0] anode_n;

    modport master (
        output value_in, load,
        input  busy, overflow, digit_out, anode_n
    );

    modport slave (
        input  value_in, load,
        output busy, overflow, digit_out, anode_n
    );
endinterface

// File: rtl/seven_seg_scan_bcd_converter.sv
// Sequential double-dabble binary-to-BCD engine with input saturation and
// leading-zero blanking; pulses commit for one cycle when digits are valid.
//
// state  | meaning
// IDLE   | waiting for load, accepts and saturates value_in
// SHIFT  | one add-3/shift step per cycle, BIN_WIDTH steps
// COMMIT | digits valid, display register captures them
import seven_seg_pkg::*;

module seven_seg_bcd_converter #(
    parameter int NUM_DIGITS = 4,
    parameter int BIN_WIDTH  = 14,
    parameter bit LZ_BLANK   = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [BIN_WIDTH-1:0]       value_in,
    input  logic                       load,
    output logic                       busy,
    output logic                       overflow,
    output logic                       commit,
    output logic [NUM_DIGITS-1:0][3:0] digits
);

    localparam int          CNT_W   = $clog2(BIN_WIDTH + 1);
    localparam logic [63:0] MAX_VAL = 64'(max_val(NUM_DIGITS));

    state_t                     state, state_nxt;
    logic [CNT_W-1:0]           cnt;
    logic [BIN_WIDTH-1:0]       bin;
    logic [NUM_DIGITS-1:0][3:0] bcd, adj;
    logic                       over;

    assign over = (64'(value_in) > MAX_VAL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (load) state_nxt = SHIFT;
            SHIFT:   if (cnt == CNT_W'(1)) state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy   = (state != IDLE);
        commit = (state == COMMIT);
    end

    always_comb begin
        adj = bcd;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd[i] >= 4'd5) adj[i] = bcd[i] + 4'd3;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            bin      <= '0;
            bcd      <= '0;
            overflow <= 1'b0;
        end else if (state == IDLE) begin
            if (load) begin
                bin      <= over ? BIN_WIDTH'(MAX_VAL) : value_in;
                overflow <= over;
                bcd      <= '0;
                cnt      <= CNT_W'(BIN_WIDTH);
            end
        end else if (state == SHIFT) begin
            {bcd, bin} <= {adj, bin} << 1;
            cnt        <= cnt - CNT_W'(1);
        end
    end

    // Scan from the top nibble down; zeros stay blank until a nonzero is seen.
    always_comb begin
        logic seen;
        seen   = 1'b0;
        digits = bcd;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            if (bcd[i] != 4'd0) seen = 1'b1;
            if (LZ_BLANK && !seen) digits[i] = BLANK_CODE;
        end
    end

endmodule

// File: rtl/seven_seg_scan_bcd.sv
// Binary value to time-multiplexed BCD digit bus: holds the converted digits
// and scans them onto digit_out with matching active-low anode enables.
import seven_seg_pkg::*;

module seven_seg_scan_bcd #(
    parameter int NUM_DIGITS  = 4,
    parameter int BIN_WIDTH   = 14,
    parameter int REFRESH_DIV = 100000,
    parameter bit LZ_BLANK    = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    seven_seg_scan_bcd_if.slave  bus
);

    localparam int DIV_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic                       commit;
    logic [NUM_DIGITS-1:0][3:0] digits;
    logic [NUM_DIGITS-1:0][3:0] disp;
    logic [DIV_W-1:0]           div;
    logic [IDX_W-1:0]           idx;

    seven_seg_bcd_converter #(
        .NUM_DIGITS (NUM_DIGITS),
        .BIN_WIDTH  (BIN_WIDTH),
        .LZ_BLANK   (LZ_BLANK)
    ) u_conv (
        .clk      (clk),
        .rst      (rst),
        .value_in (bus.value_in),
        .load     (bus.load),
        .busy     (bus.busy),
        .overflow (bus.overflow),
        .commit   (commit),
        .digits   (digits)
    );

    // Only a finished conversion reaches the display, never partial digits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         disp <= {NUM_DIGITS{BLANK_CODE}};
        else if (commit) disp <= digits;
    end

    // Digit and anode share one register stage so they always switch together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div           <= '0;
            idx           <= '0;
            bus.anode_n   <= '1;
            bus.digit_out <= BLANK_CODE;
        end else begin
            bus.anode_n   <= ~(NUM_DIGITS'(1) << idx);
            bus.digit_out <= disp[idx];
            if (div == DIV_W'(REFRESH_DIV - 1)) begin
                div <= '0;
                idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
            end else begin
                div <= div + DIV_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_bcd.sv
// Directed bench for seven_seg_scan_bcd: one instance with leading-zero blanking,
// one without, driven in lockstep and checked against hand-computed digits.
module tb_seven_seg_scan_bcd;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    seven_seg_scan_bcd_if #(.NUM_DIGITS(4), .BIN_WIDTH(14)) b1 ();
    seven_seg_scan_bcd_if #(.NUM_DIGITS(4), .BIN_WIDTH(14)) b0 ();

    seven_seg_scan_bcd #(.NUM_DIGITS(4), .BIN_WIDTH(14), .REFRESH_DIV(4), .LZ_BLANK(1'b1))
        dut_lz (.clk(clk), .rst(rst), .bus(b1));
    seven_seg_scan_bcd #(.NUM_DIGITS(4), .BIN_WIDTH(14), .REFRESH_DIV(4), .LZ_BLANK(1'b0))
        dut_nz (.clk(clk), .rst(rst), .bus(b0));

    typedef struct {
        logic [13:0] val;
        logic [15:0] exp_lz;
        logic [15:0] exp_nz;
        logic        ovf;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_load(input logic [13:0] v);
        @(negedge clk);
        b1.value_in = v; b0.value_in = v;
        b1.load = 1'b1;  b0.load = 1'b1;
        @(negedge clk);
        b1.load = 1'b0;  b0.load = 1'b0;
    endtask

    // Counts negedges with busy high; bounded so a stuck FSM cannot hang the run.
    task automatic wait_busy(output int n);
        n = 0;
        while (b1.busy && n < 40) begin
            n++;
            @(negedge clk);
        end
    endtask

    // One full scan period (4 digits x 4 clks): read the digit shown on each anode.
    task automatic capture(output logic [15:0] d1, output logic [15:0] d0, output int bad);
        logic f1, f0;
        d1 = 16'hAAAA; d0 = 16'hAAAA; bad = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            f1 = 1'b0; f0 = 1'b0;
            for (int j = 0; j < 4; j++) begin
                if (b1.anode_n == ~(4'b0001 << j)) begin d1[j*4 +: 4] = b1.digit_out; f1 = 1'b1; end
                if (b0.anode_n == ~(4'b0001 << j)) begin d0[j*4 +: 4] = b0.digit_out; f0 = 1'b1; end
            end
            if (!f1) bad++;
            if (!f0) bad++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] d1, d0;
        logic [3:0]  exp_an;
        int          n, bad;

        vecs[0] = '{14'd1234,  16'h1234, 16'h1234, 1'b0};
        vecs[1] = '{14'd7,     16'hFFF7, 16'h0007, 1'b0};
        vecs[2] = '{14'd0,     16'hFFF0, 16'h0000, 1'b0};
        vecs[3] = '{14'd12000, 16'h9999, 16'h9999, 1'b1};
        vecs[4] = '{14'd5,     16'hFFF5, 16'h0005, 1'b0};
        vecs[5] = '{14'd9999,  16'h9999, 16'h9999, 1'b0};
        vecs[6] = '{14'd10000, 16'h9999, 16'h9999, 1'b1};
        vecs[7] = '{14'd100,   16'hF100, 16'h0100, 1'b0};
        vecs[8] = '{14'd16383, 16'h9999, 16'h9999, 1'b1};

        rst = 1'b1;
        b1.value_in = '0; b0.value_in = '0;
        b1.load = 1'b0;   b0.load = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_anode",    32'(b1.anode_n),   32'hF);
        check("rst_digit",    32'(b1.digit_out), 32'hF);
        check("rst_busy",     32'(b1.busy),      32'h0);
        check("rst_overflow", 32'(b1.overflow),  32'h0);
        rst = 1'b0;
        check("rel_anode", 32'(b1.anode_n), 32'hF);

        // Blank scan right after reset: each anode held 4 clks, digit blank.
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            exp_an = ~(4'b0001 << ((k - 1) / 4));
            check("scan_anode", 32'(b1.anode_n),   32'(exp_an));
            check("scan_digit", 32'(b1.digit_out), 32'hF);
        end

        for (int v = 0; v < 9; v++) begin
            drive_load(vecs[v].val);
            wait_busy(n);
            check("busy_cycles", n, 15);
            check("overflow_lz", 32'(b1.overflow), 32'(vecs[v].ovf));
            check("overflow_nz", 32'(b0.overflow), 32'(vecs[v].ovf));
            capture(d1, d0, bad);
            check("display_lz",  32'(d1), 32'(vecs[v].exp_lz));
            check("display_nz",  32'(d0), 32'(vecs[v].exp_nz));
            check("anode_onehot", bad, 0);
        end

        // Load during the 3rd busy cycle is ignored; busy keeps its schedule.
        @(negedge clk);
        b1.value_in = 14'd1234; b0.value_in = 14'd1234;
        b1.load = 1'b1; b0.load = 1'b1;
        @(negedge clk);
        b1.load = 1'b0; b0.load = 1'b0;
        @(negedge clk);
        @(negedge clk);
        b1.value_in = 14'd9876; b0.value_in = 14'd9876;
        b1.load = 1'b1; b0.load = 1'b1;
        @(negedge clk);
        b1.load = 1'b0; b0.load = 1'b0;
        wait_busy(n);
        check("busy_remaining", n, 12);
        check("ignored_ovf", 32'(b1.overflow), 32'h0);
        capture(d1, d0, bad);
        check("ignored_disp_lz", 32'(d1), 32'h1234);
        check("ignored_disp_nz", 32'(d0), 32'h1234);

        // Reset after 5 SHIFT cycles aborts the conversion and blanks the display.
        drive_load(14'd4321);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy",  32'(b1.busy),      32'h0);
        check("abort_anode", 32'(b1.anode_n),   32'hF);
        check("abort_digit", 32'(b1.digit_out), 32'hF);
        check("abort_ovf",   32'(b1.overflow),  32'h0);
        @(negedge clk);
        rst = 1'b0;
        capture(d1, d0, bad);
        check("post_rst_lz", 32'(d1), 32'hFFFF);
        check("post_rst_nz", 32'(d0), 32'hFFFF);
        drive_load(14'd42);
        wait_busy(n);
        check("busy_after_rst", n, 15);
        capture(d1, d0, bad);
        check("after_rst_lz", 32'(d1), 32'hFF42);
        check("after_rst_nz", 32'(d0), 32'h0042);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan_bcd.md
Name: seven_seg_scan_bcd

Overview:
Upstream feeder for the 7-segment decimal decoder. It accepts a binary value, converts it to BCD with a sequential double-dabble engine, and holds the digits in a display register. It time-multiplexes those digits onto a single 4-bit digit bus with matching active-low digit enables. digit_out connects directly to the decoder's 4-bit number input; codes 10–15 produce a blank (all segments off) at the decoder.

Parameters:
NUM_DIGITS, 4, number of display digits (1–8)
BIN_WIDTH, 14, width of binary input; must be ≥ ceil(log2(10^NUM_DIGITS))
REFRESH_DIV, 100000, clk cycles each digit stays selected (≥2)
LZ_BLANK, 1, 1 = blank leading zeros (digit 0 is never blanked)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
value_in  input  BIN_WIDTH  binary value to display
load  input  1  single-cycle strobe; captures value_in when not busy
busy  output  1  high while a conversion is in progress
overflow  output  1  last accepted value exceeded 10^NUM_DIGITS-1; sticky until the next accepted load
digit_out  output  4  BCD code of the currently selected digit, 4'hF = blank
anode_n  output  NUM_DIGITS  one-hot active-low digit enable, bit i selects digit i (0 = least significant)

Behaviour:
- Reset (asynchronous): state IDLE; busy=0; overflow=0; all display digits=4'hF; scan index=0; divider=0; anode_n=all 1s; digit_out=4'hF.
- Conversion FSM states: IDLE, SHIFT, COMMIT.
- IDLE: when load=1 at an edge:
  - Capture min(value_in, MAX_VAL), where MAX_VAL = 10^NUM_DIGITS-1.
  - Set overflow = (value_in > MAX_VAL).
  - Clear the BCD accumulator, set the shift counter to BIN_WIDTH, and go to SHIFT.
- SHIFT: each cycle, first add 3 to every BCD nibble ≥5, then shift {bcd, bin} left by 1. Decrement the counter; after BIN_WIDTH shifts go to COMMIT.
- COMMIT: copy the BCD nibbles into the display register, applying leading-zero blanking if LZ_BLANK=1. Blanking replaces each zero nibble above the most significant nonzero nibble with 4'hF. Then go to IDLE.
- busy=1 in SHIFT and COMMIT. Latency: load edge to display update = BIN_WIDTH+1 cycles; busy falls on the next edge.
- load while busy is ignored. Value and overflow are unchanged by an ignored load.
- The display register changes only in COMMIT, so the scanner never shows a partial conversion.
- Scanner runs continuously from reset, independent of the FSM:
  - The divider counts 0..REFRESH_DIV-1. On wrap, the scan index advances, wrapping from NUM_DIGITS-1 to 0.
  - digit_out and anode_n are registered and update on the same edge, so there is no cycle where a stale digit is shown on a new anode.
  - After reset, the first anode is asserted at cycle 1: anode_n[0]=0 showing digit 0.
- Reset mid-conversion: abort immediately to reset values; the display blanks.
- All BCD arithmetic uses 4-bit nibbles; no nibble exceeds 9 after COMMIT.

Decomposition:
- Package seven_seg_pkg:
  - BLANK_CODE = 4'hF
  - FSM state typedef {IDLE, SHIFT, COMMIT}
  - max_val(NUM_DIGITS) constant function
- Sub-module seven_seg_bcd_converter: contains the FSM, double-dabble datapath, saturation and overflow logic. Outputs the blanked digit vector plus a commit strobe.
- The top level holds the display register, refresh divider, scan index and output registers.

Test Plan (REFRESH_DIV=4, NUM_DIGITS=4, BIN_WIDTH=14):
1. Assert rst, release; check outputs in reset state → anode_n=4'b1111, digit_out=F, busy=0. Then anode_n cycles 1110→1101→1011→0111, each held 4 clks, with digit_out=F throughout.
2. load value_in=1234 → busy high for exactly 15 cycles. Then scan shows digit_out 4,3,2,1 with anode_n bits 0,1,2,3 low respectively; overflow=0.
3. load 7 → digits {F,F,F,7}. Then load 0 → digits {F,F,F,0}. Repeat both with LZ_BLANK=0 → {0,0,0,7} and {0,0,0,0}.
4. load 12000 → overflow=1, digits 9,9,9,9. Then load 5 → overflow=0, digits {F,F,F,5}.
5. load 1234, then load 9876 on the 3rd busy cycle → second load ignored; display reads 1234 after completion.
6. load 4321; assert rst after 5 SHIFT cycles → immediate reset values and a blank display. After release, load 42 → display {F,F,4,2}.
